// File: rtl/song_sequencer_if.sv
// Note-player and song-ROM bus for song_sequencer.
// The master side belongs to the sequencer; the slave side is the player/ROM.
interface song_sequencer_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0]       rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic [DUR_W-1:0]        duration;
  logic                    new_note;
  logic                    note_done;

  modport master (
    output rom_addr, note, duration, new_note,
    input  rom_data, note_done
  );

  modport slave (
    input  rom_addr, note, duration, new_note,
    output rom_data, note_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Steps through a song block in a synchronous ROM and hands note/duration
// pairs to the note player, with loop, skip, pause and song-change handling.
module song_sequencer #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_LEN  = 32,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6,
  localparam int SONG_W   = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int IDX_W    = $clog2(SONG_LEN),
  localparam int ADDR_W   = SONG_W + IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              loop,
  input  logic              skip,
  input  logic [SONG_W-1:0] song,
  song_sequencer_if.master  bus,
  output logic              song_done,
  output logic [IDX_W-1:0]  note_index,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    HOLD,
    DONE
  } state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic                end_pending, end_pending_next;
  logic [SONG_W-1:0]   song_q;
  logic                song_ok;
  logic                song_chg;
  logic                load_note;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic [NOTE_W-1:0]   note_r;
  logic [DUR_W-1:0]    duration_r;
  logic                new_note_r;

  // Out-of-range selects only exist when NUM_SONGS is not a power of two.
  if (NUM_SONGS == (1 << SONG_W)) begin : g_all_songs_valid
    assign song_ok = 1'b1;
  end else begin : g_song_range_check
    assign song_ok = (32'(song) < 32'(NUM_SONGS));
  end

  assign song_chg = song_ok && (song != song_q);
  assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = bus.rom_data[DUR_W-1:0];

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    end_pending_next = end_pending;
    load_note        = 1'b0;

    if (song_chg) begin
      state_next       = IDLE;
      idx_next         = '0;
      end_pending_next = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play && (bus.note_done || skip)) begin
            state_next = FETCH;
          end
        end

        FETCH: begin
          if (play) begin
            state_next = LOAD;
          end
        end

        LOAD: begin
          if (play) begin
            if (rom_dur == '0) begin
              // A terminator at entry 0 is an empty song; looping it would spin forever.
              if (loop && (idx != '0)) begin
                idx_next   = '0;
                state_next = FETCH;
              end else begin
                state_next = DONE;
              end
            end else begin
              load_note  = 1'b1;
              state_next = HOLD;
              if (idx == IDX_W'(SONG_LEN - 1)) begin
                if (loop) begin
                  idx_next = '0;
                end else begin
                  end_pending_next = 1'b1;
                end
              end else begin
                idx_next = idx + IDX_W'(1);
              end
            end
          end
        end

        HOLD: begin
          if (end_pending) begin
            end_pending_next = 1'b0;
            state_next       = DONE;
          end else begin
            state_next = IDLE;
          end
        end

        DONE: begin
          state_next = DONE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      end_pending <= 1'b0;
      song_q      <= song_ok ? song : '0;
      note_r      <= '0;
      duration_r  <= '0;
      new_note_r  <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      end_pending <= end_pending_next;
      new_note_r  <= load_note;
      if (song_chg) begin
        song_q <= song;
      end
      if (load_note) begin
        note_r     <= rom_note;
        duration_r <= rom_dur;
      end
    end
  end

  assign bus.rom_addr = {song_q, idx};
  assign bus.note     = note_r;
  assign bus.duration = duration_r;
  assign bus.new_note = new_note_r;
  assign song_done    = (state == DONE);
  assign busy         = (state == FETCH) || (state == LOAD) || (state == HOLD);
  assign note_index   = idx;

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
Parametrised successor to the single-voice song reader. It steps through a song stored in an external synchronous ROM and hands note/duration pairs to the note player over a new_note / note_done handshake. Song count, song length and field widths are parameters. Adds loop mode, skip-to-next-note, an index readout and a busy flag. Sits between the top-level control (play, song select, loop, skip) and note_player.

Parameters:
NUM_SONGS, 4, number of song blocks in ROM (>=1); SONG_W = max(1, clog2(NUM_SONGS))
SONG_LEN, 32, entries per song block, power of two >=2; IDX_W = clog2(SONG_LEN)
NOTE_W, 6, note field width
DUR_W, 6, duration field width; ADDR_W = SONG_W + IDX_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
play  in  1  level; 0 = pause (no new notes issued)
loop  in  1  level; 1 = wrap to entry 0 at end of song instead of finishing
skip  in  1  one-cycle pulse; advance without waiting for note_done
song  in  SONG_W  song select
note_done  in  1  level; note_player ready for next note
rom_addr  out  ADDR_W  {song_q, idx}, combinational from registers
rom_data  in  NOTE_W+DUR_W  {note, dur}; valid 1 cycle after rom_addr
note  out  NOTE_W  registered note
duration  out  DUR_W  registered duration
new_note  out  1  one-cycle pulse, note/duration valid
song_done  out  1  level, high while in DONE
note_index  out  IDX_W  idx of next entry to fetch
busy  out  1  high in FETCH, LOAD, HOLD

Behaviour:
- Reset: state IDLE; idx 0; end_pending 0; song_q = song if song < NUM_SONGS, else 0. note, duration, new_note and song_done are all 0.
- States: IDLE, FETCH, LOAD, HOLD, DONE. new_note defaults to 0 every cycle.
- IDLE: if play & (note_done | skip), go to FETCH. Otherwise stay.
- FETCH: one-cycle ROM wait. If play, go to LOAD; else stay.
- LOAD (rom_data valid):
  - If !play: stay.
  - Else if dur == 0 (terminator):
    - loop=1 and idx != 0: idx <= 0, go to FETCH.
    - Otherwise go to DONE. A terminator at entry 0 never loops.
  - Else: note <= data note, duration <= data dur, new_note <= 1, go to HOLD.
    - idx == SONG_LEN-1: loop=1 gives idx <= 0; loop=0 gives end_pending <= 1 and idx unchanged.
    - Otherwise idx <= idx+1.
- HOLD: unconditional single cycle so note_player sees new_note before note_done is re-sampled. end_pending=1: clear it, go to DONE. Else go to IDLE.
- DONE: song_done = 1. Stays until song change or reset. play, loop and skip are ignored.
- Song change has the highest priority and is evaluated every cycle. When song != song_q and song < NUM_SONGS:
  - song_q <= song, idx <= 0, end_pending <= 0, state <= IDLE.
  - new_note is forced 0 that cycle.
  - note and duration keep their old values.
- song >= NUM_SONGS (non-power-of-two NUM_SONGS): ignored, song_q unchanged.
- Latency: with play=1 and note_done=1 in IDLE, new_note rises 2 cycles after leaving IDLE (IDLE → FETCH → LOAD edge). Minimum note-to-note spacing is 4 cycles.
- Pause: play=0 holds state in IDLE, FETCH or LOAD with idx frozen. HOLD completes regardless of play. No new_note is issued while play=0.
- note_done is level-sensitive and is only sampled in IDLE. note_done and a song change in the same cycle: the song change wins, and the next note comes from the new song's entry 0.
- Widths: idx arithmetic is modulo SONG_LEN. rom_addr never leaves the current song block.

Test Plan:
- Reset, song=1, play=1, note_done=1. ROM block 1 = (5,3), (7,2), (0,0) → new_note pulses with note/duration 5/3 then 7/2, rom_addr 32 then 33 then 34, then song_done=1 and held, busy=0.
- Same block, loop=1 → sequence 5/3, 7/2, 5/3, 7/2, … with no song_done. Block with entry 0 dur=0 and loop=1 → song_done, no hang.
- Block 2 full (32 non-zero entries), loop=0 → exactly 32 new_note pulses, note_index ends at 31, song_done one cycle after the HOLD following the 32nd pulse. With loop=1 → 33rd pulse is entry 0.
- play dropped during FETCH for 10 cycles → no new_note during the pause, rom_addr unchanged, and the next note resumes from the same entry.
- Song changed 0→3 in the same cycle as new_note would fire, and also while in DONE → no pulse that cycle, song_done=0 next cycle, next pulse is block 3 entry 0 (rom_addr 96).
- note_done=0, skip pulsed in IDLE → new_note 2 cycles later. skip in DONE or LOAD has no effect.
